// File: rtl/shift_normalizer_pkg.sv
// Purpose: shared ALU definitions for the sequential normalizer (state encoding, shift-type modes).
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package shift_normalizer_pkg;

  // Normalizer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } norm_state_e;

  // Shift-type selector, matches the ALU alufn shift-type bit.
  localparam logic MODE_LOGICAL = 1'b0;
  localparam logic MODE_ARITH   = 1'b1;

endpackage : shift_normalizer_pkg

// File: rtl/shift_normalizer_detect.sv
// Purpose: combinational normalization test on one word (done = normalized, special = all-zero/all-sign).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: word/mode in; done, special out.
module norm_detect
  import shift_normalizer_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] word,
  input  logic            mode,
  output logic            done,
  output logic            special
);

  logic all_zero;
  logic all_one;

  assign all_zero = (word == '0);
  assign all_one  = (word == '1);

  always_comb begin
    done    = 1'b0;
    special = 1'b0;
    if (mode == MODE_LOGICAL) begin
      done    = word[BITS-1];
      special = all_zero;
    end else begin
      // Arithmetic: normalized once the top two bits differ (no redundant sign bit left).
      done    = word[BITS-1] ^ word[BITS-2];
      special = all_zero | all_one;
    end
  end

endmodule : norm_detect

// File: rtl/shift_normalizer.sv
// Purpose: sequential normalizer; shifts one bit per cycle until normalized, returns word and shift count.
// Latency: k+2 cycles accept-to-valid for k shifts, 1 cycle for all-zero / all-sign shortcuts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no overlap.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/mode/a request side;
//        out_valid/out_ready/out_norm/out_count/out_zero result side.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [BITS-1:0]      a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS-1:0]      out_norm,
  output logic [$clog2(BITS):0] out_count,
  output logic                 out_zero
);

  localparam int CW = $clog2(BITS) + 1;

  norm_state_e       state_q, state_d;
  logic [BITS-1:0]   reg_q,   reg_d;
  logic [CW-1:0]     count_q, count_d;
  logic              zero_q,  zero_d;
  logic              mode_q,  mode_d;

  logic in_done;
  logic in_special;
  logic work_done;
  logic work_special;

  // Operand-side detector: only the shortcut flag matters at accept time.
  norm_detect #(.BITS(BITS)) u_detect_in (
    .word    (a),
    .mode    (mode),
    .done    (in_done),
    .special (in_special)
  );

  // Working-register detector drives the per-cycle termination test.
  norm_detect #(.BITS(BITS)) u_detect_work (
    .word    (reg_q),
    .mode    (mode_q),
    .done    (work_done),
    .special (work_special)
  );

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    count_d = count_q;
    zero_d  = zero_q;
    mode_d  = mode_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d  = mode;
          count_d = '0;
          zero_d  = 1'b0;
          if (in_special) begin
            state_d = ST_DONE;
            if (mode == MODE_LOGICAL) begin
              reg_d   = '0;
              count_d = CW'(BITS);
              zero_d  = 1'b1;
            end else begin
              reg_d   = a << (BITS - 1);
              count_d = CW'(BITS - 1);
              zero_d  = (a == '0);
            end
          end else begin
            reg_d   = a;
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        // work_special cannot arise here (shortcuts never enter SHIFT); it is a
        // defensive stop so a corrupted register can never spin forever.
        if (work_done || work_special) begin
          state_d = ST_DONE;
        end else begin
          reg_d   = reg_q << 1;
          count_d = count_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      mode_q  <= MODE_LOGICAL;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      count_q <= count_d;
      zero_q  <= zero_d;
      mode_q  <= mode_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_norm  = reg_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

  // in_done is informational for the operand path; the shortcut uses in_special.
  logic unused_in_done;
  assign unused_in_done = in_done;

endmodule : shift_normalizer

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

  localparam int BITS = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_norm;
  logic [4:0]  out_count;
  logic        out_zero;

  int checks;
  int errors;

  shift_normalizer #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_norm  (out_norm),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] av;
    logic [15:0] norm;
    int          count;
    logic        zero;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: count leading zeros / redundant sign bits by scanning the word.
  task automatic model(input logic m, input logic [15:0] av,
                       output logic [15:0] n, output int c, output logic z, output int lat);
    int lead;
    lead = 0;
    if (m == 1'b0) begin
      if (av == 16'h0) begin
        n = 16'h0; c = 16; z = 1'b1; lat = 1;
      end else begin
        while (av[15-lead] == 1'b0) lead++;
        c = lead; n = av << lead; z = 1'b0; lat = lead + 2;
      end
    end else begin
      if (av == 16'h0 || av == 16'hFFFF) begin
        n = av << 15; c = 15; z = (av == 16'h0); lat = 1;
      end else begin
        lead = 1;
        while (av[15-lead] == av[15]) lead++;
        c = lead - 1; n = av << (lead - 1); z = 1'b0; lat = lead + 1;
      end
    end
  endtask

  // Called at posedge+1 with DUT in IDLE. Returns latency in edges (0 = timeout).
  task automatic do_op(input logic m, input logic [15:0] av, output int lat,
                       output logic [15:0] n, output logic [4:0] c, output logic z);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; mode = m; a = av;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); mode = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for out_valid a=0x%0h mode=%0d", av, m);
    end
    n = out_norm; c = out_count; z = out_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", in_ready, 1);
    chk("out_valid_after_release", out_valid, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int          lat;
    logic [15:0] n;
    logic [4:0]  c;
    logic        z;
    logic [15:0] en;
    int          ec;
    logic        ez;
    int          elat;
    logic [15:0] rv;
    logic        rm;

    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; a = 16'h0; out_ready = 1'b0;

    vecs[0] = '{1'b0, 16'h00F0, 16'hF000,  8, 1'b0, 10};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16, 1'b1,  1};
    vecs[2] = '{1'b1, 16'hFF80, 16'h8000,  8, 1'b0, 10};
    vecs[3] = '{1'b1, 16'h4000, 16'h4000,  0, 1'b0,  2};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h8000, 15, 1'b0,  1};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000,  0, 1'b0,  2};
    vecs[6] = '{1'b0, 16'h0001, 16'h8000, 15, 1'b0, 17};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 15, 1'b1,  1};
    vecs[8] = '{1'b1, 16'h0001, 16'h4000, 14, 1'b0, 16};
    vecs[9] = '{1'b1, 16'h8000, 16'h8000,  0, 1'b0,  2};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_norm", out_norm, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_out_zero", out_zero, 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].m, vecs[i].av, lat, n, c, z);
      chk($sformatf("vec%0d_norm", i), n, vecs[i].norm);
      chk($sformatf("vec%0d_count", i), c, vecs[i].count);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].zero);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      release_result();
    end

    // Backpressure: result held, stray requests ignored.
    do_op(1'b0, 16'h00F0, lat, n, c, z);
    chk("bp_latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); mode = 1'b0; a = 16'h1234;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_norm", out_norm, 16'hF000);
      chk("bp_count", out_count, 8);
      chk("bp_zero", out_zero, 0);
    end
    in_valid = 1'b0;
    release_result();
    @(posedge clk); #1;
    chk("bp_no_capture_in_ready", in_ready, 1);
    chk("bp_no_capture_out_valid", out_valid, 0);

    // Reset mid-SHIFT discards work.
    in_valid = 1'b1; mode = 1'b0; a = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_count", out_count, 0);
    chk("midrst_out_norm", out_norm, 0);
    do_op(1'b0, 16'h0100, lat, n, c, z);
    chk("postrst_count", c, 7);
    chk("postrst_norm", n, 16'h8000);
    chk("postrst_latency", lat, 9);
    release_result();

    // Randomized against the scan model, with random result backpressure.
    for (int i = 0; i < 300; i++) begin
      rm = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       rv = 16'h0000;
        1:       rv = 16'hFFFF;
        default: begin
          rv = 16'($urandom) >> $urandom_range(0, 15);
          if ($urandom_range(0, 1) == 1) rv = ~rv;
        end
      endcase
      model(rm, rv, en, ec, ez, elat);
      do_op(rm, rv, lat, n, c, z);
      chk($sformatf("rnd_norm a=%0h m=%0d", rv, rm), n, en);
      chk($sformatf("rnd_count a=%0h m=%0d", rv, rm), c, ec);
      chk($sformatf("rnd_zero a=%0h m=%0d", rv, rm), z, ez);
      chk($sformatf("rnd_latency a=%0h m=%0d", rv, rm), lat, elat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_norm", out_norm, en);
      end
      release_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_normalizer
